// File: rtl/cr_clic_int_req_if.sv
// Core-side CLIC request/claim bundle: arbiter winner and priorities in,
// level request and one-hot claim pulse out.
interface cr_clic_int_req_if #(
  parameter int INT_NUM    = 32,
  parameter int ID_WIDTH   = 5,
  parameter int PRIO_WIDTH = 6
);
  logic [INT_NUM-1:0]            arb_sel_onehot;
  logic [PRIO_WIDTH*INT_NUM-1:0] int_prio_vec;
  logic [INT_NUM-1:0]            int_pending;
  logic [PRIO_WIDTH-1:0]         cpu_int_thresh;
  logic                          cpu_int_en;
  logic                          cpu_int_ack;
  logic                          clic_cpu_int_req;
  logic [ID_WIDTH-1:0]           clic_cpu_int_id;
  logic [PRIO_WIDTH-1:0]         clic_cpu_int_prio;
  logic                          clic_int_claim_vld;
  logic [INT_NUM-1:0]            clic_int_claim_onehot;

  // Controller side
  modport slave (
    input  arb_sel_onehot, int_prio_vec, int_pending,
           cpu_int_thresh, cpu_int_en, cpu_int_ack,
    output clic_cpu_int_req, clic_cpu_int_id, clic_cpu_int_prio,
           clic_int_claim_vld, clic_int_claim_onehot
  );

  // Arbiter/core side
  modport master (
    output arb_sel_onehot, int_prio_vec, int_pending,
           cpu_int_thresh, cpu_int_en, cpu_int_ack,
    input  clic_cpu_int_req, clic_cpu_int_id, clic_cpu_int_prio,
           clic_int_claim_vld, clic_int_claim_onehot
  );
endinterface

// File: rtl/cr_clic_int_req.sv
// Interrupt request/claim controller: qualifies the arbiter winner against
// threshold and enable, holds a level request to the core (retargeting while
// waiting) and returns a one-cycle one-hot claim on acknowledge.
//
// state | meaning
// IDLE  | no request outstanding; id/prio hold their last value
// REQ   | request presented to the core, candidate may retarget it
// CLAIM | one-cycle claim pulse for the acknowledged id
module cr_clic_int_req #(
  parameter int INT_NUM    = 32,
  parameter int ID_WIDTH   = 5,
  parameter int PRIO_WIDTH = 6
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  cr_clic_int_req_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    CLAIM = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [PRIO_WIDTH-1:0] prio_q, prio_d;

  logic [ID_WIDTH-1:0]   cand_id;
  logic [PRIO_WIDTH-1:0] cand_prio;
  logic                  cand_pend;
  logic                  cand_ok;

  // Encode the one-hot winner into id and priority with OR-based muxing
  always_comb begin
    cand_id   = '0;
    cand_prio = '0;
    for (int k = 0; k < INT_NUM; k++) begin
      if (bus.arb_sel_onehot[k]) begin
        cand_id = cand_id | ID_WIDTH'(k);
      end
      cand_prio = cand_prio |
                  (bus.int_prio_vec[PRIO_WIDTH*k +: PRIO_WIDTH] & {PRIO_WIDTH{bus.arb_sel_onehot[k]}});
    end
  end

  assign cand_pend = |(bus.arb_sel_onehot & bus.int_pending);
  assign cand_ok   = bus.cpu_int_en & cand_pend & (cand_prio > bus.cpu_int_thresh);

  // State and latched request registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= IDLE;
      id_q    <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
    end
  end

  // Next state; ack dominates retarget and withdraw while requesting
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    prio_d  = prio_q;
    case (state_q)
      IDLE: begin
        if (cand_ok) begin
          state_d = REQ;
          id_d    = cand_id;
          prio_d  = cand_prio;
        end
      end
      REQ: begin
        if (bus.cpu_int_ack) begin
          state_d = CLAIM;
        end else if (cand_ok) begin
          id_d   = cand_id;
          prio_d = cand_prio;
        end else begin
          state_d = IDLE;
        end
      end
      CLAIM:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.clic_cpu_int_req      = (state_q == REQ);
  assign bus.clic_cpu_int_id       = id_q;
  assign bus.clic_cpu_int_prio     = prio_q;
  assign bus.clic_int_claim_vld    = (state_q == CLAIM);
  // Ids beyond INT_NUM shift out and yield an all-zero claim
  assign bus.clic_int_claim_onehot = (state_q == CLAIM) ? (INT_NUM'(1) << id_q) : '0;

endmodule
